// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared constants, FSM encoding and helpers for the write-back port arbiter
package wb_port_arbiter_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_FPU = 2'd1;
    localparam logic [1:0] SRC_LSU = 2'd2;
    localparam logic [1:0] SRC_MDU = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Requester index reached by stepping off positions past base, wrapping mod 4.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int unsigned off);
        logic [1:0] o;
        o = off[1:0];
        return base + o;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: requester-side and write-back-side handshake bundle of the arbiter
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int Size = 64
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*Size-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    wb_valid;
    logic                    wb_ready;
    logic [Size-1:0]         wb_data;
    logic [1:0]              wb_src;

    modport master (
        input  req_valid, req_data, wb_ready,
        output req_ready, wb_valid, wb_data, wb_src
    );

    modport slave (
        output req_valid, req_data, wb_ready,
        input  req_ready, wb_valid, wb_data, wb_src
    );
endinterface

// File: rtl/wb_port_arbiter_mux_4to1.sv
// mux_4to1: four-way payload selector used on the write-back data path
module mux_4to1 #(
    parameter int Size = 64
) (
    input  logic [Size-1:0] d0,
    input  logic [Size-1:0] d1,
    input  logic [Size-1:0] d2,
    input  logic [Size-1:0] d3,
    input  logic [1:0]      sel,
    output logic [Size-1:0] y
);
    assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin sharing of the register-file write-back port among ALU/FPU/LSU/MDU
// Optional performance counters are built when WB_ARB_PERF_EN is defined.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int Size     = 64,
    parameter int CntWidth = 32
) (
    input  logic clk,
    input  logic rst_n,
    wb_port_arbiter_if.master bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [NUM_REQ*CntWidth-1:0] grant_cnt,
    output logic [CntWidth-1:0]         stall_cnt
`endif
);
    state_t          state;
    state_t          state_nxt;
    logic [1:0]      ptr;
    logic [1:0]      g;
    logic            found;
    logic            can_load;
    logic            xfer;
    logic [Size-1:0] mux_out;

    assign bus.wb_valid = (state == FULL);
    assign can_load     = ~bus.wb_valid | bus.wb_ready;
    assign xfer         = found & can_load;
    assign bus.req_ready = (xfer & rst_n) ? (4'b0001 << g) : 4'b0000;

    // Pick the first valid requester starting at ptr; walking downward lets the nearest one win.
    always_comb begin
        found = 1'b0;
        g     = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[rr_idx(ptr, k)]) begin
                found = 1'b1;
                g     = rr_idx(ptr, k);
            end
        end
    end

    mux_4to1 #(.Size(Size)) u_mux (
        .d0  (bus.req_data[0*Size +: Size]),
        .d1  (bus.req_data[1*Size +: Size]),
        .d2  (bus.req_data[2*Size +: Size]),
        .d3  (bus.req_data[3*Size +: Size]),
        .sel (g),
        .y   (mux_out)
    );

    // Output register occupancy: a transfer always fills it, a drain without refill empties it.
    always_comb begin
        state_nxt = state;
        state_nxt = xfer ? FULL : (bus.wb_ready ? EMPTY : state);
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Capture the winning payload and advance the round-robin pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_data <= '0;
            bus.wb_src  <= 2'd0;
            ptr         <= 2'd0;
        end else if (xfer) begin
            bus.wb_data <= mux_out;
            bus.wb_src  <= g;
            ptr         <= g + 2'd1;
        end
    end

`ifdef WB_ARB_PERF_EN
    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && g == 2'(i) && grant_cnt[i*CntWidth +: CntWidth] != '1)
                    grant_cnt[i*CntWidth +: CntWidth] <= grant_cnt[i*CntWidth +: CntWidth] + 1'b1;
            end
        end
    end

    // Saturating count of cycles the register file holds off a pending payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (bus.wb_valid && !bus.wb_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed table-driven bench for the write-back port arbiter
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int Size     = 64;
    localparam int CntWidth = 32;
    localparam int NV       = 23;

    typedef struct {
        logic [3:0] rv;
        logic       wr;
        logic [3:0] rr;
        logic       v;
        logic [1:0] src;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    vec_t tbl [NV];
    logic [Size-1:0] dval [4];

    wb_port_arbiter_if #(.Size(Size)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [4*CntWidth-1:0] grant_cnt;
    logic [CntWidth-1:0]   stall_cnt;
    wb_port_arbiter #(.Size(Size), .CntWidth(CntWidth)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    wb_port_arbiter #(.Size(Size), .CntWidth(CntWidth)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        dval[0] = 64'h0123_4567_89AB_CDEF;
        dval[1] = 64'h1111_2222_3333_4444;
        dval[2] = 64'h0000_0000_DEAD_BEEF;
        dval[3] = 64'hFEDC_BA98_7654_3210;
        //            rv       wr    rr       v     src
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, SRC_ALU};
        tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, SRC_LSU};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, SRC_LSU};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, SRC_MDU};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, SRC_ALU};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, SRC_FPU};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, SRC_LSU};
        tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, SRC_MDU};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, SRC_ALU};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, SRC_FPU};
        tbl[10] = '{4'b1111, 1'b1, 4'b0100, 1'b1, SRC_LSU};
        tbl[11] = '{4'b1111, 1'b1, 4'b1000, 1'b1, SRC_MDU};
        tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, SRC_FPU};
        tbl[13] = '{4'b1000, 1'b0, 4'b0000, 1'b1, SRC_FPU};
        tbl[14] = '{4'b1000, 1'b0, 4'b0000, 1'b1, SRC_FPU};
        tbl[15] = '{4'b1000, 1'b0, 4'b0000, 1'b1, SRC_FPU};
        tbl[16] = '{4'b1000, 1'b1, 4'b1000, 1'b1, SRC_MDU};
        tbl[17] = '{4'b1001, 1'b1, 4'b0001, 1'b1, SRC_ALU};
        tbl[18] = '{4'b1001, 1'b1, 4'b1000, 1'b1, SRC_MDU};
        tbl[19] = '{4'b0000, 1'b0, 4'b0000, 1'b1, SRC_MDU};
        tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, SRC_MDU};
        tbl[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0, SRC_MDU};
        tbl[22] = '{4'b0100, 1'b0, 4'b0100, 1'b1, SRC_LSU};

        bus.req_data  = {dval[3], dval[2], dval[1], dval[0]};
        bus.req_valid = 4'b1111;
        bus.wb_ready  = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset wb_data", bus.wb_data, 64'd0);
        chk("reset wb_src", 64'(bus.wb_src), 64'd0);

        for (int i = 0; i < NV; i++) begin
            rst_n         = 1'b1;
            bus.req_valid = tbl[i].rv;
            bus.wb_ready  = tbl[i].wr;
            #1;
            chk($sformatf("row%0d req_ready", i), 64'(bus.req_ready), 64'(tbl[i].rr));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d wb_valid", i), 64'(bus.wb_valid), 64'(tbl[i].v));
            chk($sformatf("row%0d wb_src", i), 64'(bus.wb_src), 64'(tbl[i].src));
            chk($sformatf("row%0d wb_data", i), bus.wb_data, dval[tbl[i].src]);
            @(negedge clk);
        end

`ifdef WB_ARB_PERF_EN
        chk("grant_cnt alu", 64'(grant_cnt[0*CntWidth +: CntWidth]), 64'd4);
        chk("grant_cnt fpu", 64'(grant_cnt[1*CntWidth +: CntWidth]), 64'd3);
        chk("grant_cnt lsu", 64'(grant_cnt[2*CntWidth +: CntWidth]), 64'd4);
        chk("grant_cnt mdu", 64'(grant_cnt[3*CntWidth +: CntWidth]), 64'd5);
        chk("stall_cnt", 64'(stall_cnt), 64'd4);
`endif

        bus.req_valid = 4'b1010;
        bus.wb_ready  = 1'b0;
        #1;
        chk("pre-reset wb_valid", 64'(bus.wb_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("async reset wb_data", bus.wb_data, 64'd0);
        chk("async reset wb_src", 64'(bus.wb_src), 64'd0);
        chk("async reset req_ready", 64'(bus.req_ready), 64'd0);
`ifdef WB_ARB_PERF_EN
        chk("async reset grant_cnt", 64'(grant_cnt != '0), 64'd0);
        chk("async reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n        = 1'b1;
        bus.wb_ready = 1'b1;
        #1;
        chk("post-reset ptr req_ready", 64'(bus.req_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        chk("post-reset wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("post-reset wb_src", 64'(bus.wb_src), 64'(SRC_FPU));
        chk("post-reset wb_data", bus.wb_data, dval[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Round-robin arbiter that shares the single integer/FP register-file write-back port between four producers: 0 = ALU, 1 = FPU, 2 = load unit, 3 = mul/div.
- Instantiates the existing 4-to-1 mux for the data path.
- Buffers the winner in a one-entry output register with a valid/ready handshake.
- Sits between the execute-stage units and the register-file write port.

Parameters:
- Size, 64, width of each write-back payload in bits.
- CntWidth, 32, width of each performance counter (used only with WB_ARB_PERF_EN).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  per-requester valid; bit i = requester i.
- req_data  input  4*Size  packed payloads; requester i in bits [i*Size +: Size].
- req_ready  output  4  per-requester accept, one-hot or zero.
- wb_valid  output  1  output register holds a payload.
- wb_ready  input  1  register file accepts the payload this cycle.
- wb_data  output  Size  registered payload.
- wb_src  output  2  index of the requester that produced wb_data.
- grant_cnt  output  4*CntWidth  per-requester grant counters (WB_ARB_PERF_EN only).
- stall_cnt  output  CntWidth  cycles with wb_valid=1 and wb_ready=0 (WB_ARB_PERF_EN only).

Behaviour:
- Reset is asynchronous: on rst_n low, all state clears immediately.
  - wb_valid=0, wb_data=0, wb_src=0.
  - RR pointer ptr=0.
  - Counters=0.
  - req_ready=0 while rst_n is low.
- A reset during operation drops any in-flight payload; the requester must re-present it.
- FSM states:
  - EMPTY (wb_valid=0).
  - FULL (wb_valid=1).
- The output register can load when `can_load = ~wb_valid | wb_ready`.
- Arbitration is combinational each cycle.
  - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first requester with req_valid set wins; call it g.
- req_ready[g] = can_load; all other bits are 0. When no request is valid, req_ready=0.
- A transfer from requester g happens when req_valid[g] & req_ready[g]. On that edge:
  - wb_data <= req_data[g], selected through mux_4to1 with sel=g.
  - wb_src <= g, wb_valid <= 1.
  - ptr <= g+1 (mod 4, 2-bit wrap).
- The ptr value is unchanged on cycles with no transfer.
- FSM transitions:
  - EMPTY to FULL on a transfer.
  - FULL to EMPTY on wb_ready with no new transfer.
  - FULL to FULL on wb_ready plus a same-cycle transfer (back-to-back, one payload per cycle).
  - FULL stays FULL when wb_ready=0; wb_data and wb_src hold, and req_ready=0.
- Latency: one cycle from accept to wb_valid.
- Requester contract:
  - Once req_valid[i] is asserted, it stays high with req_data stable until accepted.
  - The arbiter never asserts req_ready for a requester whose req_valid is low.
- Fairness: any continuously asserted requester is granted within 4 transfers.
- wb_valid does not depend combinationally on wb_ready. req_ready does depend on wb_ready.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- Defined:
  - grant_cnt[i] increments on each transfer from requester i.
  - stall_cnt increments on each cycle with wb_valid & ~wb_ready.
  - All counters saturate at all-ones.
  - Counters reset to 0 asynchronously.
- Undefined:
  - The counter ports and logic are absent.
  - Arbitration behaviour is identical.

Decomposition:
- Shared package:
  - Requester index constants: SRC_ALU=2'd0, SRC_FPU=2'd1, SRC_LSU=2'd2, SRC_MDU=2'd3.
  - Number of requesters: 4.
  - FSM state encoding: EMPTY=1'b0, FULL=1'b1.
- Sub-module: the existing mux_4to1 with #(.Size(Size)), sel driven by g. No other sub-module.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> wb_valid=0, req_ready=4'b0000, wb_data=0. Release; first edge grants requester 0 -> wb_src=0.
- Single request: req_valid=4'b0100, data2=64'hDEAD_BEEF, wb_ready=1 -> req_ready=4'b0100, then next cycle wb_valid=1, wb_data=64'hDEAD_BEEF, wb_src=2.
- Round-robin: all four requesters valid, wb_ready=1 for 8 cycles -> wb_src sequence 0,1,2,3,0,1,2,3, one payload per cycle.
- Stall/back-pressure: FULL with wb_src=1, wb_ready=0 for 3 cycles -> wb_data stable, req_ready=0. Then wb_ready=1 with req 3 valid -> same-edge swap to wb_src=3.
- Pointer wrap: after a grant to requester 3, requests 0 and 3 both valid -> requester 0 wins.
- Reset mid-operation: assert rst_n=0 while FULL -> wb_valid drops immediately without a clock edge, ptr=0. With WB_ARB_PERF_EN: grant_cnt all 0, stall_cnt=0.
